addr_arbiter: RTL and testbench

- Shares one `addr` adder/subtractor instance between NREQ independent requesters.
- Round-robin grant; sequences the adder's start/done handshake; returns sum/cout to the granted requester with a one-cycle response pulse.
- Sits between client blocks and the single `addr` instance; the adder's `nrst` is driven from the same reset.

---
 rtl/addr_arb_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/addr_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_addr_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addr_arb_pkg.sv
// Shared definitions for the addr adder arbiter: FSM state encodings,
// state width, default abort timeout and an index-width helper.
// Imported by addr_arbiter and rr_arbiter.
package addr_arb_pkg;

  localparam int ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_ISSUE = 2'd1;
  localparam logic [ST_W-1:0] ST_WAIT  = 2'd2;
  localparam logic [ST_W-1:0] ST_RESP  = 2'd3;

  localparam int DEF_TIMEOUT = 64;

  // Width of an index into an n-entry vector (never zero).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purpose: combinational round-robin select, first set request at or after ptr_i (wrapping).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to act on vld_o.
// Ports: req_i request vector, ptr_i priority pointer (< N),
//        gnt_o one-hot winner, idx_o winner index, vld_o any request present.
module rr_arbiter
  import addr_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  logic [N-1:0] rot;
  logic [IW:0]  idx_sum;
  logic         found;

  always_comb begin
    // Rotate so that bit 0 is the requester at the pointer; the lowest set
    // bit of rot is then the winner, offset by ptr_i.
    rot     = N'({req_i, req_i} >> ptr_i);
    found   = 1'b0;
    idx_sum = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found   = 1'b1;
        idx_sum = {1'b0, ptr_i} + (IW+1)'(k);
      end
    end
    if (idx_sum >= (IW+1)'(N)) begin
      idx_sum = idx_sum - (IW+1)'(N);
    end
    idx_o = idx_sum[IW-1:0];
    vld_o = found;
    gnt_o = found ? (N'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/addr_arbiter.sv
// Purpose: shares one addr adder/subtractor among NREQ requesters, round-robin.
// Latency: 4 cycles minimum (IDLE, ISSUE, WAIT with done, RESP), plus adder time in WAIT.
// Backpressure: requesters hold req until their rsp_valid bit; losers simply wait.
// Ports: clk/nrst (sync active-low); req/req_addsub/req_a/req_b per requester;
//        gnt/rsp_valid one-hot; rsp_sum/rsp_cout/rsp_err response; busy;
//        addr_* start/operands out and sum/cout/done in from the adder.
// Optional: define ADDR_ARB_TIMEOUT_EN to abort a WAIT longer than TIMEOUT cycles
//        with rsp_err=1; otherwise rsp_err is tied low and TIMEOUT is unused.
module addr_arbiter
  import addr_arb_pkg::*;
#(
  parameter int BIT     = 4,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     req_addsub,
  input  logic [NREQ*BIT-1:0] req_a,
  input  logic [NREQ*BIT-1:0] req_b,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     rsp_valid,
  output logic [BIT-1:0]      rsp_sum,
  output logic                rsp_cout,
  output logic                rsp_err,
  output logic                busy,
  output logic                addr_start,
  output logic                addr_addsub,
  output logic [BIT-1:0]      addr_a,
  output logic [BIT-1:0]      addr_b,
  input  logic [BIT-1:0]      addr_sum,
  input  logic                addr_cout,
  input  logic                addr_done
);

  localparam int IW = idx_w(NREQ);

  logic [ST_W-1:0] state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [BIT-1:0]  rsp_sum_q, rsp_sum_d;
  logic            rsp_cout_q, rsp_cout_d;
  logic            start_q, start_d;
  logic            addsub_q, addsub_d;
  logic [BIT-1:0]  a_q, a_d;
  logic [BIT-1:0]  b_q, b_d;

  logic [NREQ-1:0] win_oh;
  logic [IW-1:0]   win_idx;
  logic            win_vld;

`ifdef ADDR_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wcnt_q, wcnt_d;
  logic          rsp_err_q, rsp_err_d;
`endif

  rr_arbiter #(.N(NREQ)) u_rr (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (win_oh),
    .idx_o (win_idx),
    .vld_o (win_vld)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gidx_d      = gidx_q;
    gnt_d       = gnt_q;
    rsp_valid_d = '0;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    start_d     = 1'b0;
    addsub_d    = addsub_q;
    a_d         = a_q;
    b_d         = b_q;
`ifdef ADDR_ARB_TIMEOUT_EN
    wcnt_d      = wcnt_q;
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          // Operands are captured here; later changes by the requester are ignored.
          state_d  = ST_ISSUE;
          gnt_d    = win_oh;
          gidx_d   = win_idx;
          start_d  = 1'b1;
          addsub_d = req_addsub[win_idx];
          a_d      = req_a[int'(win_idx)*BIT +: BIT];
          b_d      = req_b[int'(win_idx)*BIT +: BIT];
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
`ifdef ADDR_ARB_TIMEOUT_EN
        wcnt_d  = '0;
`endif
      end
      ST_WAIT: begin
        if (addr_done) begin
          state_d     = ST_RESP;
          rsp_valid_d = gnt_q;
          rsp_sum_d   = addr_sum;
          rsp_cout_d  = addr_cout;
`ifdef ADDR_ARB_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
        end
`ifdef ADDR_ARB_TIMEOUT_EN
        // wcnt_q counts completed WAIT cycles minus one; this is the last allowed one.
        else if (wcnt_q == TW'(TIMEOUT - 1)) begin
          state_d     = ST_RESP;
          rsp_valid_d = gnt_q;
          rsp_sum_d   = '0;
          rsp_cout_d  = 1'b0;
          rsp_err_d   = 1'b1;
        end else begin
          wcnt_d = wcnt_q + TW'(1);
        end
`endif
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        ptr_d   = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + IW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      gidx_q      <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      start_q     <= 1'b0;
      addsub_q    <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
`ifdef ADDR_ARB_TIMEOUT_EN
      wcnt_q      <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gidx_q      <= gidx_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      start_q     <= start_d;
      addsub_q    <= addsub_d;
      a_q         <= a_d;
      b_q         <= b_d;
`ifdef ADDR_ARB_TIMEOUT_EN
      wcnt_q      <= wcnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

`ifdef ADDR_ARB_TIMEOUT_EN
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign gnt         = gnt_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_sum     = rsp_sum_q;
  assign rsp_cout    = rsp_cout_q;
  assign busy        = (state_q != ST_IDLE);
  assign addr_start  = start_q;
  assign addr_addsub = addsub_q;
  assign addr_a      = a_q;
  assign addr_b      = b_q;

endmodule

// File: tb/tb_addr_arbiter.sv
// Bench for addr_arbiter: behavioural adder with random latency, requester
// queues, and a scoreboard fed by a transaction-level round-robin model.
module tb_addr_arbiter;

  localparam int BIT  = 4;
  localparam int NREQ = 4;
  localparam int TO   = 8;

  logic                clk  = 1'b0;
  logic                nrst = 1'b0;
  logic [NREQ-1:0]     req, req_addsub;
  logic [NREQ*BIT-1:0] req_a, req_b;
  logic [NREQ-1:0]     gnt, rsp_valid;
  logic [BIT-1:0]      rsp_sum;
  logic                rsp_cout, rsp_err, busy;
  logic                addr_start, addr_addsub;
  logic [BIT-1:0]      addr_a, addr_b, addr_sum;
  logic                addr_cout, addr_done;

  typedef struct { logic [3:0] a; logic [3:0] b; logic sub; } op_t;
  typedef struct {
    int idx; logic [3:0] a; logic [3:0] b; logic sub;
    logic [3:0] sum; logic cout; logic err;
  } exp_t;

  op_t  opq[NREQ][$];
  op_t  stage[NREQ][$];
  exp_t exp_q[$];

  int checks = 0, errors = 0;
  int ptr_m = 0, n_ops = 0, n_starts = 0;
  bit stuck = 1'b0;

  addr_arbiter #(.BIT(BIT), .NREQ(NREQ), .TIMEOUT(TO)) dut (
    .clk(clk), .nrst(nrst), .req(req), .req_addsub(req_addsub),
    .req_a(req_a), .req_b(req_b), .gnt(gnt), .rsp_valid(rsp_valid),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_err(rsp_err), .busy(busy),
    .addr_start(addr_start), .addr_addsub(addr_addsub), .addr_a(addr_a),
    .addr_b(addr_b), .addr_sum(addr_sum), .addr_cout(addr_cout),
    .addr_done(addr_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // Arithmetic meaning of an operation, independent of any adder structure.
  function automatic exp_t ref_result(input int i, input op_t o, input bit timed_out);
    exp_t e;
    int   s;
    e.idx = i; e.a = o.a; e.b = o.b; e.sub = o.sub; e.err = 1'b0;
    if (timed_out) begin
      e.sum = 4'd0; e.cout = 1'b0; e.err = 1'b1;
    end else if (o.sub) begin
      s = int'(o.a) - int'(o.b);
      e.cout = (s >= 0);          // carry-out of a subtract means no borrow
      if (s < 0) s += 16;
      e.sum = s[3:0];
    end else begin
      s = int'(o.a) + int'(o.b);
      e.cout = (s >= 16);
      if (s >= 16) s -= 16;
      e.sum = s[3:0];
    end
    return e;
  endfunction

  function automatic void add_op(input int i, input int a, input int b, input int sub);
    op_t o;
    o.a = 4'(a); o.b = 4'(b); o.sub = 1'(sub);
    stage[i].push_back(o);
  endfunction

  // Service order: repeatedly take the first requester at/after the pointer
  // that still has work, then move the pointer past it.
  function automatic void plan();
    int pos[NREQ];
    int left = 0;
    int p = ptr_m;
    for (int i = 0; i < NREQ; i++) begin
      pos[i] = 0;
      left += stage[i].size();
    end
    n_ops += left;
    while (left > 0) begin
      for (int k = 0; k < NREQ; k++) begin
        int i = (p + k) % NREQ;
        if (pos[i] < stage[i].size()) begin
          exp_q.push_back(ref_result(i, stage[i][pos[i]], stuck));
          pos[i]++;
          left--;
          p = (i + 1) % NREQ;
          break;
        end
      end
    end
    ptr_m = p;
  endfunction

  function automatic void submit();
    for (int i = 0; i < NREQ; i++) begin
      foreach (stage[i][j]) opq[i].push_back(stage[i][j]);
      stage[i].delete();
    end
  endfunction

  function automatic void clear_stage();
    for (int i = 0; i < NREQ; i++) stage[i].delete();
  endfunction

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < NREQ; i++) n += opq[i].size();
    return n;
  endfunction

  task automatic wait_drain();
    int cyc = 0;
    int budget = 30 * (exp_q.size() + 1) + 40;
    while (cyc < budget && (exp_q.size() > 0 || pending() > 0)) begin
      @(posedge clk);
      cyc++;
    end
    chk("drain_outstanding", exp_q.size() + pending(), 0);
    if (exp_q.size() + pending() != 0) finish_sim();
  endtask

  task automatic run_batch();
    @(posedge clk); #2;
    plan();
    submit();
    wait_drain();
    @(negedge clk);
    chk("busy_idle", int'(busy), 0);
  endtask

  task automatic wait_start();
    int c = 0;
    do begin @(negedge clk); c++; end while (!addr_start && c < 50);
    chk("start_seen", int'(addr_start), 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"},       int'(gnt), 0);
    chk({tag, "_rsp_valid"}, int'(rsp_valid), 0);
    chk({tag, "_rsp_sum"},   int'(rsp_sum), 0);
    chk({tag, "_rsp_cout"},  int'(rsp_cout), 0);
    chk({tag, "_rsp_err"},   int'(rsp_err), 0);
    chk({tag, "_busy"},      int'(busy), 0);
    chk({tag, "_start"},     int'(addr_start), 0);
    chk({tag, "_addsub"},    int'(addr_addsub), 0);
    chk({tag, "_addr_a"},    int'(addr_a), 0);
    chk({tag, "_addr_b"},    int'(addr_b), 0);
  endtask

  // Requesters: present the head of their queue, retire it on their rsp_valid.
  initial begin
    req = '0; req_addsub = '0; req_a = '0; req_b = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (rsp_valid[i] && opq[i].size() > 0) void'(opq[i].pop_front());
        if (opq[i].size() > 0) begin
          req[i]                = 1'b1;
          req_a[i*BIT +: BIT]   = opq[i][0].a;
          req_b[i*BIT +: BIT]   = opq[i][0].b;
          req_addsub[i]         = opq[i][0].sub;
        end else begin
          req[i]                = 1'b0;
          req_a[i*BIT +: BIT]   = 4'($urandom);
          req_b[i*BIT +: BIT]   = 4'($urandom);
          req_addsub[i]         = 1'($urandom);
        end
      end
    end
  end

  // Behavioural adder: done 1..4 cycles after start, garbage on sum otherwise.
  initial begin
    int         cd;
    logic       prev_start;
    op_t        cap;
    logic [4:0] tmp;
    cd = 0; prev_start = 1'b0;
    addr_done = 1'b0; addr_sum = '0; addr_cout = 1'b0;
    forever begin
      @(negedge clk);
      addr_done = 1'b0;
      addr_sum  = 4'($urandom);
      addr_cout = 1'($urandom);
      if (!nrst) cd = 0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          chk("wait_stable_a", int'(addr_a), int'(cap.a));
          chk("wait_stable_b", int'(addr_b), int'(cap.b));
          chk("wait_stable_op", int'(addr_addsub), int'(cap.sub));
          tmp = {1'b0, cap.a} + {1'b0, (cap.sub ? ~cap.b : cap.b)} + {4'b0, cap.sub};
          addr_sum  = tmp[3:0];
          addr_cout = tmp[4];
          addr_done = 1'b1;
        end
      end
      if (addr_start) begin
        n_starts++;
        chk("start_one_cycle", int'(prev_start), 0);
        chk("busy_issue", int'(busy), 1);
        if (exp_q.size() > 0) begin
          chk("gnt_issue", int'(gnt), 1 << exp_q[0].idx);
          chk("issue_a", int'(addr_a), int'(exp_q[0].a));
          chk("issue_b", int'(addr_b), int'(exp_q[0].b));
          chk("issue_op", int'(addr_addsub), int'(exp_q[0].sub));
        end
        cap.a = addr_a; cap.b = addr_b; cap.sub = addr_addsub;
        if (!stuck) cd = $urandom_range(1, 4);
      end
      prev_start = addr_start;
    end
  end

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid != '0) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected: rsp_valid=%b with nothing expected at %0t", rsp_valid, $time);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_valid", int'(rsp_valid), 1 << e.idx);
          chk("gnt_resp", int'(gnt), 1 << e.idx);
          chk("rsp_sum", int'(rsp_sum), int'(e.sum));
          chk("rsp_cout", int'(rsp_cout), int'(e.cout));
          chk("rsp_err", int'(rsp_err), int'(e.err));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    checks++; errors++;
    $display("FAIL watchdog: simulation time limit reached");
    finish_sim();
  end

  initial begin
    int s0, n, c, cnt;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    nrst = 1'b1;

    // Simultaneous r1 (7-3) and r2 (9+6) from pointer 0.
    add_op(1, 7, 3, 1); add_op(2, 9, 6, 0);
    run_batch();

    // Lone r0 5+3, exactly one start pulse.
    s0 = n_starts;
    add_op(0, 5, 3, 0);
    run_batch();
    chk("single_start", n_starts - s0, 1);

    // r3 15+1 wraps to 0 with carry.
    add_op(3, 15, 1, 0);
    run_batch();

    // All four continuously requesting, two ops each: order 0,1,2,3,0,1,2,3.
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++)
        add_op(i, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1));
    run_batch();

    // Random batches.
    for (int r = 0; r < 25; r++) begin
      n = 0;
      for (int i = 0; i < NREQ; i++) begin
        cnt = $urandom_range(0, 2);
        for (int j = 0; j < cnt; j++) begin
          add_op(i, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1));
          n++;
        end
      end
      if (n == 0) add_op($urandom_range(0, NREQ - 1), $urandom_range(0, 15), $urandom_range(0, 15), 0);
      run_batch();
    end

    // Reset during WAIT: pointer is 3 after serving r2, so r3 wins first.
    add_op(2, 1, 1, 0);
    run_batch();
    stuck = 1'b1;
    @(posedge clk); #2;
    add_op(1, 2, 2, 0); add_op(3, 6, 1, 1);
    submit();
    n_ops += 1;
    wait_start();
    chk("gnt_before_reset", int'(gnt), 8);
    repeat (2) @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    chk_zero("midreset");
    nrst  = 1'b1;
    stuck = 1'b0;
    ptr_m = 0;
    add_op(1, 2, 2, 0); add_op(3, 6, 1, 1);
    plan();
    clear_stage();
    wait_drain();

`ifdef ADDR_ARB_TIMEOUT_EN
    // Stuck done: abort after TO WAIT cycles, then normal service resumes.
    stuck = 1'b1;
    @(posedge clk); #2;
    add_op(2, 9, 9, 0);
    plan();
    submit();
    wait_start();
    c = 0;
    do begin @(negedge clk); c++; end while (rsp_valid == '0 && c < 200);
    chk("timeout_cycles", c, TO + 1);
    wait_drain();
    stuck = 1'b0;
    add_op(2, 4, 4, 0);
    run_batch();
`endif

    chk("start_count", n_starts, n_ops);
    finish_sim();
  end

endmodule
